// File: rtl/br_resolve_pkg.sv
// Shared constants and helpers for branch resolution: funct3 decode, BHT geometry,
// counter width and the BHT reset value.
package br_resolve_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    localparam int              BHT_DEPTH   = 16;
    localparam int              BHT_IDX_W   = 4;
    localparam int              CNT_W       = 16;
    localparam logic [1:0]      BHT_RST_VAL = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // funct3 010/011 are not branch encodings; they resolve not-taken.
    function automatic logic br_taken(input logic [2:0] f3, input logic less, input logic equal);
        case (f3)
            F3_BEQ:           return equal;
            F3_BNE:           return ~equal;
            F3_BLT, F3_BLTU:  return less;
            F3_BGE, F3_BGEU:  return ~less;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Execute-stage branch bundle: instruction info, comparator flags and the
// unsigned-compare select returned to the comparator.
interface br_resolve_if;
    logic        ex_valid_i;
    logic        ex_is_br_i;
    logic        ex_is_jmp_i;
    logic [2:0]  funct3_i;
    logic        br_unsign_o;
    logic        br_less_i;
    logic        br_equal_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;

    modport slave (
        input  ex_valid_i, ex_is_br_i, ex_is_jmp_i, funct3_i,
        input  br_less_i, br_equal_i, ex_pc_i, ex_target_i, ex_pred_taken_i,
        output br_unsign_o
    );

    modport master (
        output ex_valid_i, ex_is_br_i, ex_is_jmp_i, funct3_i,
        output br_less_i, br_equal_i, ex_pc_i, ex_target_i, ex_pred_taken_i,
        input  br_unsign_o
    );
endinterface

// File: rtl/br_bht.sv
// Branch history table: 2-bit saturating counters, async prediction read,
// synchronous update from the resolving branch.
module br_bht
    import br_resolve_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BHT_IDX_W-1:0] rd_idx_i,
    output logic                 rd_pred_o,
    input  logic                 upd_en_i,
    input  logic [BHT_IDX_W-1:0] upd_idx_i,
    input  logic                 upd_taken_i
);

    logic [1:0] ctr_q [BHT_DEPTH];

    // Read returns pre-edge contents; a same-cycle update is not bypassed.
    assign rd_pred_o = ctr_q[rd_idx_i][1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= BHT_RST_VAL;
            end
        end else if (upd_en_i) begin
            if (upd_taken_i && ctr_q[upd_idx_i] != 2'b11) begin
                ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] + 2'd1;
            end else if (!upd_taken_i && ctr_q[upd_idx_i] != 2'b00) begin
                ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/br_resolve.sv
// Branch/jump resolution in EX: taken decode, mispredict redirect, BHT training
// and resolved/mispredict statistics.
module br_resolve
    import br_resolve_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      if_pc_i,
    output logic             if_pred_taken_o,
    br_resolve_if.slave      ex,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic             taken;
    logic             resolve;
    logic             is_cond;
    logic             mispred;
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             unused_if_pc;

    assign unused_if_pc   = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0]};
    assign ex.br_unsign_o = ex.funct3_i[1];

    always_comb begin
        taken         = ex.ex_is_jmp_i | br_taken(ex.funct3_i, ex.br_less_i, ex.br_equal_i);
        // While a redirect is out, the EX slot holds a wrong-path instruction.
        resolve       = ex.ex_valid_i & (ex.ex_is_br_i | ex.ex_is_jmp_i) & ~redirect_q;
        is_cond       = resolve & ~ex.ex_is_jmp_i;
        mispred       = resolve & (taken != ex.ex_pred_taken_i);
        redirect_d    = mispred;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        if (mispred) begin
            redirect_pc_d = taken ? ex.ex_target_i : ex.ex_pc_i + 32'd4;
        end
        if (is_cond && br_cnt_q != CNT_MAX) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (is_cond && mispred && mis_cnt_q != CNT_MAX) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    br_bht u_bht (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (if_pc_i[BHT_IDX_W+1:2]),
        .rd_pred_o   (if_pred_taken_o),
        .upd_en_i    (is_cond),
        .upd_idx_i   (ex.ex_pc_i[BHT_IDX_W+1:2]),
        .upd_taken_i (taken)
    );

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mis_cnt_q;

endmodule
